// File: rtl/distribute.sv
// distribute: one-entry demux joining a data stream with a destination-index stream,
// with a once-per-round lane mask. Optional round auto-clear: DISTRIBUTE_AUTOCLR_EN.

module distribute_lane #(
  parameter int I    = 1,
  parameter int LANE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_val,
  input  logic [I-1:0] i_idx,
  input  logic [I-1:0] i_sel,
  input  logic         i_load,
  input  logic         i_clr,
  output logic         o_stb,
  output logic         o_mask
);
  logic w_hit, w_set, r_mask;

  assign w_hit  = (i_idx == I'(LANE));
  assign w_set  = i_load & (i_sel == I'(LANE));
  assign o_stb  = i_val & w_hit;
  assign o_mask = r_mask;

  // A same-cycle acceptance wins over a round clear for this lane.
  always_ff @(posedge clk or negedge rst)
    if (!rst)        r_mask <= 1'b0;
    else if (w_set)  r_mask <= 1'b1;
    else if (i_clr)  r_mask <= 1'b0;
endmodule

module distribute #(
  parameter  int W = 16,
  parameter  int N = 2,
  localparam int I = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           s_stb,
  input  logic [W-1:0]   s_dat,
  output logic           s_rdy,
  input  logic           n_stb,
  input  logic [I-1:0]   n_dat,
  output logic           n_rdy,
  output logic [N-1:0]   m_stb,
  output logic [N*W-1:0] m_dat,
  input  logic [N-1:0]   m_rdy,
  output logic [N-1:0]   mask,
  output logic           err,
  output logic           done
);
  localparam int NP = 1 << I;

  logic          r_val, r_err, r_done;
  logic [I-1:0]  r_idx;
  logic [W-1:0]  r_dat;
  logic [N-1:0]  w_mask;
  logic [NP-1:0] w_mask_p, w_rdy_p;
  logic          w_oor, w_drain, w_space, w_ok, w_acc, w_load, w_aclr, w_clr;

  // Pad to the full index range so an out-of-range index never selects past the vector.
  assign w_mask_p = NP'(w_mask);
  assign w_rdy_p  = NP'(m_rdy);

  assign w_oor   = (int'(n_dat) >= N);
  assign w_drain = r_val & w_rdy_p[r_idx];
  assign w_space = ~r_val | w_drain;
  assign w_ok    = w_oor | ~w_mask_p[n_dat];
  assign w_acc   = s_stb & n_stb & w_space & w_ok;
  assign w_load  = w_acc & ~w_oor;
  assign s_rdy   = rst & n_stb & w_space & w_ok;
  assign n_rdy   = rst & s_stb & w_space & w_ok;

`ifdef DISTRIBUTE_AUTOCLR_EN
  assign w_aclr = (&w_mask) & w_space;
`else
  assign w_aclr = 1'b0;
`endif
  assign w_clr = clr | w_aclr;

  for (genvar g = 0; g < N; g++) begin : g_lane
    distribute_lane #(.I(I), .LANE(g)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_val  (r_val),
      .i_idx  (r_idx),
      .i_sel  (n_dat),
      .i_load (w_load),
      .i_clr  (w_clr),
      .o_stb  (m_stb[g]),
      .o_mask (w_mask[g])
    );
  end

  assign mask  = w_mask;
  assign m_dat = {N{r_dat}};
  assign err   = r_err;
  assign done  = r_done;

  // Every acceptance implies a free slot, so the else branch covers both a plain
  // drain and a dropped out-of-range word.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_val  <= 1'b0;
      r_idx  <= '0;
      r_dat  <= '0;
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_err  <= w_acc & w_oor;
      r_done <= w_aclr;
      if (w_load) begin
        r_val <= 1'b1;
        r_idx <= n_dat;
        r_dat <= s_dat;
      end else if (w_space) begin
        r_val <= 1'b0;
      end
    end
endmodule

// File: tb/tb_distribute.sv
// Bench for distribute (W=16, N=4): vector table plus hand sequences, delivery scoreboard.
module tb_distribute;
  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst, clr, s_stb, n_stb, s_rdy, n_rdy, err, done;
  logic [W-1:0]   s_dat;
  logic [1:0]     n_dat;
  logic [N-1:0]   m_stb, m_rdy, mask;
  logic [N*W-1:0] m_dat;

  distribute #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .s_stb(s_stb), .s_dat(s_dat), .s_rdy(s_rdy),
    .n_stb(n_stb), .n_dat(n_dat), .n_rdy(n_rdy),
    .m_stb(m_stb), .m_dat(m_dat), .m_rdy(m_rdy),
    .mask(mask), .err(err), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s_stb;
    logic [15:0] s_dat;
    logic        n_stb;
    logic [1:0]  n_dat;
    logic [3:0]  m_rdy;
    logic        clr;
    logic        e_srdy, e_nrdy;
    logic [3:0]  e_mstb, e_mask;
    logic        e_done;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];
  vec_t tbl[16];

  function automatic vec_t mk(input logic ss, input logic [15:0] sd, input logic ns,
                              input logic [1:0] nd, input logic [3:0] rdy, input logic c,
                              input logic es, input logic en, input logic [3:0] em,
                              input logic [3:0] ek, input logic ed);
    vec_t v;
    v.s_stb = ss; v.s_dat = sd; v.n_stb = ns; v.n_dat = nd; v.m_rdy = rdy; v.clr = c;
    v.e_srdy = es; v.e_nrdy = en; v.e_mstb = em; v.e_mask = ek; v.e_done = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge: drive, check handshakes and deliveries, clock once, check registers.
  task automatic step(input vec_t v, input string nm);
    logic [31:0] e;
    s_stb = v.s_stb; s_dat = v.s_dat; n_stb = v.n_stb; n_dat = v.n_dat;
    m_rdy = v.m_rdy; clr = v.clr;
    #1;
    chk({nm, ".s_rdy"}, 32'(s_rdy), 32'(v.e_srdy));
    chk({nm, ".n_rdy"}, 32'(n_rdy), 32'(v.e_nrdy));
    for (int i = 0; i < N; i++) begin
      if (m_stb[i] & m_rdy[i]) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL %s.dlv: got unexpected delivery lane %0d want none", nm, i);
        end else begin
          e = sb.pop_front();
          chk({nm, ".dlv"}, {14'd0, 2'(i), m_dat[i*W +: W]}, e);
        end
      end
    end
    if (v.s_stb & v.n_stb & v.e_srdy) sb.push_back({14'd0, v.n_dat, v.s_dat});
    @(posedge clk);
    @(negedge clk);
    chk({nm, ".m_stb"}, 32'(m_stb), 32'(v.e_mstb));
    chk({nm, ".mask"},  32'(mask),  32'(v.e_mask));
    chk({nm, ".err"},   32'(err),   32'd0);
    chk({nm, ".done"},  32'(done),  32'(v.e_done));
  endtask

  initial begin
    //            s  dat      n  nd rdy   clr srdy nrdy mstb     mask     done
    tbl[0]  = mk(1, 16'hA5A5, 1, 2, 4'hF, 0,  1,  1,  4'b0100, 4'b0100, 0); // basic route
    tbl[1]  = mk(0, 16'h0000, 0, 0, 4'hF, 0,  0,  0,  4'b0000, 4'b0100, 0);
    tbl[2]  = mk(1, 16'h1111, 1, 0, 4'hF, 0,  1,  1,  4'b0001, 4'b0101, 0); // mask stall
    tbl[3]  = mk(1, 16'h2222, 1, 0, 4'hF, 0,  0,  0,  4'b0000, 4'b0101, 0);
    tbl[4]  = mk(1, 16'h2222, 1, 0, 4'hF, 0,  0,  0,  4'b0000, 4'b0101, 0);
    tbl[5]  = mk(1, 16'h2222, 1, 0, 4'hF, 1,  0,  0,  4'b0000, 4'b0000, 0);
    tbl[6]  = mk(1, 16'h2222, 1, 0, 4'hF, 0,  1,  1,  4'b0001, 4'b0001, 0);
    tbl[7]  = mk(1, 16'h3333, 0, 1, 4'hF, 0,  0,  1,  4'b0000, 4'b0001, 0); // join
    tbl[8]  = mk(1, 16'h3333, 0, 1, 4'hF, 0,  0,  1,  4'b0000, 4'b0001, 0);
    tbl[9]  = mk(1, 16'h3333, 0, 1, 4'hF, 0,  0,  1,  4'b0000, 4'b0001, 0);
    tbl[10] = mk(1, 16'h3333, 1, 1, 4'hF, 0,  1,  1,  4'b0010, 4'b0011, 0);
    tbl[11] = mk(0, 16'h0000, 0, 0, 4'hF, 0,  0,  0,  4'b0000, 4'b0011, 0);
    tbl[12] = mk(1, 16'h4444, 1, 2, 4'hF, 1,  1,  1,  4'b0100, 4'b0100, 0); // acc beats clr
    tbl[13] = mk(1, 16'h5555, 1, 3, 4'hF, 0,  1,  1,  4'b1000, 4'b1100, 0); // no bubble
    tbl[14] = mk(0, 16'h0000, 0, 0, 4'hF, 0,  0,  0,  4'b0000, 4'b1100, 0);
    tbl[15] = mk(0, 16'h0000, 0, 0, 4'hF, 1,  0,  0,  4'b0000, 4'b0000, 0);

    rst = 1'b0; clr = 1'b0; s_stb = 1'b0; n_stb = 1'b0; s_dat = '0; n_dat = '0; m_rdy = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_stb = 1'b1; n_stb = 1'b1; #1;
    chk("rst.m_stb", 32'(m_stb), 32'd0);
    chk("rst.m_dat", m_dat[31:0], 32'd0);
    chk("rst.mask",  32'(mask),  32'd0);
    chk("rst.err",   32'(err),   32'd0);
    chk("rst.done",  32'(done),  32'd0);
    chk("rst.s_rdy", 32'(s_rdy), 32'd0);
    chk("rst.n_rdy", 32'(n_rdy), 32'd0);
    s_stb = 1'b0; n_stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 16; k++) step(tbl[k], $sformatf("tbl%0d", k));

    // Back-pressure: lane 1 held, second pair stalls, accepted the cycle lane 1 drains.
    step(mk(1, 16'hBEEF, 1, 1, 4'h0, 0, 1, 1, 4'b0010, 4'b0010, 0), "bp.load");
    for (int k = 0; k < 5; k++) begin
      step(mk(1, 16'hCAFE, 1, 3, 4'h0, 0, 0, 0, 4'b0010, 4'b0010, 0), "bp.hold");
      chk("bp.dat", 32'(m_dat[31:16]), 32'h0000BEEF);
    end
    step(mk(1, 16'hCAFE, 1, 3, 4'b0010, 0, 1, 1, 4'b1000, 4'b1010, 0), "bp.rel");
    step(mk(0, 16'h0000, 0, 0, 4'hF,    0, 0, 0, 4'b0000, 4'b1010, 0), "bp.drain");

    // Asynchronous reset with a word pending on lane 3.
    step(mk(0, 16'h0000, 0, 0, 4'h0, 1, 0, 0, 4'b0000, 4'b0000, 0), "ar.clr");
    step(mk(1, 16'hD00D, 1, 3, 4'h0, 0, 1, 1, 4'b1000, 4'b1000, 0), "ar.load");
    s_stb = 1'b1; n_stb = 1'b1; n_dat = 2'd0; m_rdy = 4'h0;
    #3 rst = 1'b0;
    #1;
    chk("ar.m_stb", 32'(m_stb), 32'd0);
    chk("ar.mask",  32'(mask),  32'd0);
    chk("ar.s_rdy", 32'(s_rdy), 32'd0);
    chk("ar.n_rdy", 32'(n_rdy), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;

    // Round of all four lanes back-to-back.
    step(mk(1, 16'hA000, 1, 0, 4'hF, 0, 1, 1, 4'b0001, 4'b0001, 0), "ac.l0");
    step(mk(1, 16'hA001, 1, 1, 4'hF, 0, 1, 1, 4'b0010, 4'b0011, 0), "ac.l1");
    step(mk(1, 16'hA002, 1, 2, 4'hF, 0, 1, 1, 4'b0100, 4'b0111, 0), "ac.l2");
    step(mk(1, 16'hA003, 1, 3, 4'hF, 0, 1, 1, 4'b1000, 4'b1111, 0), "ac.l3");
`ifdef DISTRIBUTE_AUTOCLR_EN
    step(mk(0, 16'h0000, 0, 0, 4'hF, 0, 0, 0, 4'b0000, 4'b0000, 1), "ac.done");
    step(mk(1, 16'hA004, 1, 0, 4'hF, 0, 1, 1, 4'b0001, 4'b0001, 0), "ac.next");
`else
    step(mk(0, 16'h0000, 0, 0, 4'hF, 0, 0, 0, 4'b0000, 4'b1111, 0), "ac.keep");
    step(mk(1, 16'hA004, 1, 0, 4'hF, 0, 0, 0, 4'b0000, 4'b1111, 0), "ac.stall");
`endif
    step(mk(0, 16'h0000, 0, 0, 4'hF, 1, 0, 0, 4'b0000, 4'b0000, 0), "end.clr");
    chk("sb.empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
